// File: rtl/adder_pkg.sv
// Shared definitions for the chunked pipelined adder.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );

endinterface

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit
// so the last stage can derive signed overflow.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  always_comb begin
    logic carry;
    carry = cin;
    s     = '0;
    cmsb  = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) cmsb = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract split into WIDTH/CHUNK carry-registered stages; the whole pipe
// advances together and stalls when the output is held.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave bus
);

  localparam int STAGES = (CHUNK > 0) ? WIDTH / CHUNK : 1;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic                          advance;
  logic [STAGES-1:0][WIDTH-1:0]  src_as;
  logic [STAGES-1:0][WIDTH-1:0]  src_b;
  logic [STAGES-1:0]             src_c;
  logic [STAGES-1:0]             src_v;
  logic [STAGES-1:0][CHUNK-1:0]  chunk_s;
  logic [STAGES-1:0]             chunk_c;
  logic [STAGES-1:0]             chunk_m;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             overflow_q;
  logic             unused_bits;

  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  // src_as holds unprocessed A bits in the low end and finished sum chunks
  // shifted in from the top, so every stage consumes bits [CHUNK-1:0].
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_as[0] = bus.a;
      assign src_b[0]  = bus.b ^ {WIDTH{bus.mode == MODE_SUB}};
      assign src_c[0]  = (bus.mode == MODE_SUB);
      assign src_v[0]  = bus.in_valid;
    end else begin : g_reg
      logic [WIDTH-1:0] as_q;
      logic [WIDTH-1:0] b_q;
      logic             c_q;
      logic             v_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          as_q <= '0;
          b_q  <= '0;
          c_q  <= 1'b0;
          v_q  <= 1'b0;
        end else if (advance) begin
          as_q <= WIDTH'({chunk_s[k-1], src_as[k-1]} >> CHUNK);
          b_q  <= src_b[k-1] >> CHUNK;
          c_q  <= chunk_c[k-1];
          v_q  <= src_v[k-1];
        end
      end

      assign src_as[k] = as_q;
      assign src_b[k]  = b_q;
      assign src_c[k]  = c_q;
      assign src_v[k]  = v_q;
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (src_as[k][CHUNK-1:0]),
      .b    (src_b[k][CHUNK-1:0]),
      .cin  (src_c[k]),
      .s    (chunk_s[k]),
      .cout (chunk_c[k]),
      .cmsb (chunk_m[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (advance) begin
      out_valid_q <= src_v[STAGES-1];
      sum_q       <= WIDTH'({chunk_s[STAGES-1], src_as[STAGES-1]} >> CHUNK);
      carry_q     <= chunk_c[STAGES-1];
      overflow_q  <= chunk_c[STAGES-1] ^ chunk_m[STAGES-1];
    end
  end

  // Only the last stage's MSB carry and low B bits matter.
  assign unused_bits = ^{chunk_m, src_b[STAGES-1]};

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized and directed bench for pipelined_adder with a queue scoreboard
// fed by an arithmetic reference model.
module tb_pipelined_adder;
  import adder_pkg::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  int   out16_cnt = 0;
  int   out4_cnt  = 0;

  logic [17:0] exp16_q[$];
  logic [17:0] exp4_q[$];
  logic [17:0] e16;
  logic [17:0] e4;

  pipelined_adder_if #(.WIDTH(16)) bus16 ();
  pipelined_adder_if #(.WIDTH(4))  bus4 ();

  pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  pipelined_adder #(.WIDTH(4), .CHUNK(1)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Returns {overflow, carry_out, sum} from plain signed/unsigned arithmetic.
  function automatic logic [17:0] model(input int w, input int a, input int b, input logic mode);
    int mask, half, r, sa, sb, sr;
    logic c, o;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    if (mode == MODE_SUB) begin
      r  = a - b;
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      r  = a + b;
      c  = (r > mask);
      sr = sa + sb;
    end
    o = (sr >= half) || (sr < -half);
    return {o, c, 16'(r & mask)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp16_q.delete();
    end else begin
      if (bus16.out_valid && bus16.out_ready) begin
        checkOutput("d16_pending", exp16_q.size() > 0, 1);
        if (exp16_q.size() > 0) begin
          e16 = exp16_q.pop_front();
          checkOutput("d16_sum", bus16.sum, e16[15:0]);
          checkOutput("d16_carry", bus16.carry_out, e16[16]);
          checkOutput("d16_overflow", bus16.overflow, e16[17]);
        end
        out16_cnt++;
      end
      if (bus16.in_valid && bus16.in_ready)
        exp16_q.push_back(model(16, int'(bus16.a), int'(bus16.b), bus16.mode));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp4_q.delete();
    end else begin
      if (bus4.out_valid && bus4.out_ready) begin
        checkOutput("d4_pending", exp4_q.size() > 0, 1);
        if (exp4_q.size() > 0) begin
          e4 = exp4_q.pop_front();
          checkOutput("d4_sum", bus4.sum, e4[3:0]);
          checkOutput("d4_carry", bus4.carry_out, e4[16]);
          checkOutput("d4_overflow", bus4.overflow, e4[17]);
        end
        out4_cnt++;
      end
      if (bus4.in_valid && bus4.in_ready)
        exp4_q.push_back(model(4, int'(bus4.a), int'(bus4.b), bus4.mode));
    end
  end

  // Called just after a rising edge; holds the operation until accepted.
  task automatic applyStimulus(input bit use4, input logic [15:0] a, input logic [15:0] b, input logic mode);
    logic acc;
    acc = 1'b0;
    if (use4) begin
      bus4.in_valid = 1'b1;
      bus4.a = a[3:0];
      bus4.b = b[3:0];
      bus4.mode = mode;
    end else begin
      bus16.in_valid = 1'b1;
      bus16.a = a;
      bus16.b = b;
      bus16.mode = mode;
    end
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = use4 ? bus4.in_ready : bus16.in_ready;
      @(posedge clk);
      #1;
    end
    if (use4) bus4.in_valid = 1'b0;
    else bus16.in_valid = 1'b0;
    checkOutput("accept", acc, 1);
  endtask

  task automatic runDirected(input logic [15:0] a, input logic [15:0] b, input logic mode,
                             input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    checkOutput("dir_ready", bus16.in_ready, 1);
    bus16.in_valid = 1'b1;
    bus16.a = a;
    bus16.b = b;
    bus16.mode = mode;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (bus16.out_valid) break;
      @(posedge clk);
      lat++;
    end
    checkOutput("dir_latency", lat, 4);
    checkOutput("dir_sum", bus16.sum, es);
    checkOutput("dir_carry", bus16.carry_out, ec);
    checkOutput("dir_overflow", bus16.overflow, eo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int  cnt0;
    int  cyc0;
    bit  done;

    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.mode = MODE_ADD; bus16.out_ready = 1'b1;
    bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.mode  = MODE_ADD; bus4.out_ready  = 1'b1;

    #2;
    checkOutput("rst_out_valid", bus16.out_valid, 0);
    checkOutput("rst_sum", bus16.sum, 0);
    checkOutput("rst_carry", bus16.carry_out, 0);
    checkOutput("rst_overflow", bus16.overflow, 0);
    checkOutput("rst_d4_valid", bus4.out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("release_ready", bus16.in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    runDirected(16'h00FF, 16'h0001, MODE_ADD, 16'h0100, 1'b0, 1'b0);
    runDirected(16'hFFFF, 16'h0001, MODE_ADD, 16'h0000, 1'b1, 1'b0);
    runDirected(16'h7FFF, 16'h0001, MODE_ADD, 16'h8000, 1'b0, 1'b1);
    runDirected(16'h0005, 16'h0007, MODE_SUB, 16'hFFFE, 1'b0, 1'b0);
    runDirected(16'h8000, 16'h0001, MODE_SUB, 16'h7FFF, 1'b1, 1'b1);

    $display("[TB] back-pressure with five operations");
    cnt0 = out16_cnt;
    bus16.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          applyStimulus(1'b0, 16'(16'h1234 * (i + 1)), 16'(16'h0F0F + 16'(i * 77)), 1'(i & 1));
      end
      begin
        for (int t = 0; t < 20 && bus16.in_ready; t++) @(negedge clk);
        checkOutput("stall_ready_low", bus16.in_ready, 0);
        repeat (3) @(posedge clk);
        #1 bus16.out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    checkOutput("stall_drained", exp16_q.size(), 0);
    checkOutput("stall_count", out16_cnt - cnt0, 5);

    $display("[TB] randomized traffic");
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          applyStimulus(1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus16.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus16.out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rand_drained", exp16_q.size(), 0);

    $display("[TB] reset with operations in flight");
    bus16.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 16'(16'h0100 + i), 16'h0011, MODE_ADD);
    @(posedge clk);
    #1;
    checkOutput("pre_rst_valid", bus16.out_valid, 1);
    cnt0 = out16_cnt;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", bus16.out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus16.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", bus16.in_ready, 1);
    checkOutput("post_rst_valid", bus16.out_valid, 0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("no_stale_results", out16_cnt - cnt0, 0);
    runDirected(16'h1234, 16'h1111, MODE_SUB, 16'h0123, 1'b1, 1'b0);

    $display("[TB] exhaustive WIDTH=4 CHUNK=1");
    cnt0 = out4_cnt;
    cyc0 = cycle;
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          applyStimulus(1'b1, 16'(x), 16'(y), 1'(m));
    checkOutput("d4_throughput", cycle - cyc0, 512);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("d4_drained", exp4_q.size(), 0);
    checkOutput("d4_count", out4_cnt - cnt0, 512);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
